au_seq: RTL and testbench

AU_SEQ -- requirements
Module: au_seq

---
 rtl/au_seq_pkg.sv | 30 +++
 rtl/au_seq.sv | 195 +++++++++++++++++++
 tb/tb_au_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/au_seq_pkg.sv
// au_seq_pkg: shared AU operation codes, FSM state encoding and a code-select helper.
package au_seq_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_IDLE = 3'd0;
    localparam logic [SEL_W-1:0] SEL_ADD  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_SUB  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_ADC  = 3'd5;
    localparam logic [SEL_W-1:0] SEL_SBC  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // First nibble starts a fresh add/sub; later nibbles chain through the AU's held carry.
    function automatic logic [SEL_W-1:0] au_code(input logic sub, input logic first);
        logic [SEL_W-1:0] code;
        if (first) begin
            code = sub ? SEL_SUB : SEL_ADD;
        end else begin
            code = sub ? SEL_SBC : SEL_ADC;
        end
        return code;
    endfunction

endpackage

// File: rtl/au_seq.sv
// au_seq: sequences a multi-nibble add/subtract through an external 4-bit AU,
// one nibble per cycle, LSB first, chaining carry through the AU's held cout.
// Optional feature: define AU_SEQ_OVF_EN to compute the signed overflow flag;
// otherwise ovf is tied to 0.
module au_seq
    import au_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   zero,
    output logic                   ovf,
    output logic [SEL_W-1:0]       au_sel,
    output logic [NIB_W-1:0]       au_a,
    output logic [NIB_W-1:0]       au_b,
    input  logic [NIB_W-1:0]       au_out,
    input  logic                   au_cout,
    input  logic                   au_z
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NIB_W-1:0]   au_a_q, au_a_d;
    logic [NIB_W-1:0]   au_b_q, au_b_d;
    logic               last_c;

    // Constant-indexed nibble read, avoids variable part-select width issues.
    function automatic logic [NIB_W-1:0] nib_of(input logic [W-1:0] v, input logic [IDX_W-1:0] i);
        logic [NIB_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NIBBLES); k++) begin
            if (i == IDX_W'(k)) begin
                r = v[NIB_W*k +: NIB_W];
            end
        end
        return r;
    endfunction

    assign last_c = (idx_q == IDX_W'(NIBBLES - 1));

    // Next-state, datapath capture and registered AU drive for the coming cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sel_d    = SEL_IDLE;
        au_a_d   = '0;
        au_b_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    sel_d   = au_code(op, 1'b1);
                    au_a_d  = op_a[NIB_W-1:0];
                    au_b_d  = op_b[NIB_W-1:0];
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                for (int k = 0; k < int'(NIBBLES); k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        result_d[NIB_W*k +: NIB_W] = au_out;
                    end
                end
                carry_d = au_cout;
                zero_d  = (idx_q == '0) ? au_z : (zero_q & au_z);
                if (last_c) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    sel_d  = au_code(op_q, 1'b0);
                    au_a_d = nib_of(a_q, idx_d);
                    au_b_d = nib_of(b_q, idx_d);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= SEL_IDLE;
            au_a_q   <= '0;
            au_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sel_q    <= sel_d;
            au_a_q   <= au_a_d;
            au_b_q   <= au_b_d;
        end
    end

`ifdef AU_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow from operand MSBs and the final result nibble's MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_RUN && last_c) begin
            if (op_q) begin
                ovf_d = (a_q[W-1] != b_q[W-1]) && (au_out[NIB_W-1] != a_q[W-1]);
            end else begin
                ovf_d = (a_q[W-1] == b_q[W-1]) && (au_out[NIB_W-1] != a_q[W-1]);
            end
        end
    end

    // Overflow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign au_sel = sel_q;
    assign au_a   = au_a_q;
    assign au_b   = au_b_q;

endmodule

// File: tb/tb_au_seq.sv
// tb_au_seq: directed bench for au_seq with a behavioural 4-bit AU holding its cout.
module tb_au_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;
`ifdef AU_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         ovf;
    logic [2:0]   au_sel;
    logic [3:0]   au_a;
    logic [3:0]   au_b;
    logic [3:0]   au_out;
    logic         au_cout;
    logic         au_z;

    int n_tests;
    int n_fail;

    au_seq #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .ovf     (ovf),
        .au_sel  (au_sel),
        .au_a    (au_a),
        .au_b    (au_b),
        .au_out  (au_out),
        .au_cout (au_cout),
        .au_z    (au_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural AU: combinational result, cout held as carry-in for codes 5/6.
    logic       cin_q;
    logic [4:0] au_full;
    always_comb begin
        case (au_sel)
            3'd1:    au_full = {1'b0, au_a} + {1'b0, au_b};
            3'd2:    au_full = {1'b0, au_a} - {1'b0, au_b};
            3'd5:    au_full = {1'b0, au_a} + {1'b0, au_b} + {4'd0, cin_q};
            3'd6:    au_full = {1'b0, au_a} - {1'b0, au_b} - {4'd0, cin_q};
            default: au_full = 5'd0;
        endcase
    end
    assign au_out  = au_full[3:0];
    assign au_cout = au_full[4];
    assign au_z    = (au_full[3:0] == 4'd0);

    always_ff @(posedge clk) begin
        if (au_sel != 3'd0) cin_q <= au_cout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation; poke_cyc>0 re-asserts start with other operands in that RUN cycle,
    // start_in_done asserts start during the DONE cycle.
    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r,
                          input logic exp_c, input logic exp_z, input logic exp_v,
                          input int poke_cyc, input logic start_in_done);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            check({tag, " busy_run"}, 32'(busy), 32'd1);
            check({tag, " done_run"}, 32'(done), 32'd0);
            if (k == 1) check({tag, " sel_first"}, 32'(au_sel), o ? 32'd2 : 32'd1);
            else        check({tag, " sel_chain"}, 32'(au_sel), o ? 32'd6 : 32'd5);
            if (k == poke_cyc) begin
                start = 1'b1;
                op    = ~o;
                op_a  = ~a;
                op_b  = 16'h5A5A;
            end
            step();
            start = 1'b0;
        end
        check({tag, " done"},   32'(done),   32'd1);
        check({tag, " busy_d"}, 32'(busy),   32'd1);
        check({tag, " sel_d"},  32'(au_sel), 32'd0);
        check({tag, " result"}, 32'(result), 32'(exp_r));
        check({tag, " carry"},  32'(carry),  32'(exp_c));
        check({tag, " zero"},   32'(zero),   32'(exp_z));
        check({tag, " ovf"},    32'(ovf),    32'(exp_v));
        if (start_in_done) begin
            start = 1'b1;
            op_a  = 16'h1111;
            op_b  = 16'h2222;
        end
        step();
        start = 1'b0;
        check({tag, " done_off"}, 32'(done),   32'd0);
        check({tag, " busy_off"}, 32'(busy),   32'd0);
        check({tag, " hold"},     32'(result), 32'(exp_r));
        step();
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_sel"},  32'(au_sel), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        op_a    = '0;
        op_b    = '0;
        #12;
        check("rst busy",   32'(busy),   32'd0);
        check("rst done",   32'(done),   32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags",  32'({carry, zero, ovf}), 32'd0);
        check("rst sel",    32'(au_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("add1",  1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0,   0, 1'b0);
        run_op("addwr", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0,   0, 1'b0);
        run_op("sub1",  1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0,   0, 1'b0);
        run_op("subun", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0,   0, 1'b0);
        run_op("addov", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, OVF_EN, 0, 1'b0);
        run_op("subov", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, OVF_EN, 0, 1'b0);
        // Second start mid-run and start in DONE must both be ignored.
        run_op("poke",  1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0, 1'b0,   2, 1'b1);

        // Reset mid-RUN at idx=2.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        op_a  = 16'h1234;
        op_b  = 16'h4321;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid busy",   32'(busy),   32'd0);
        check("mid done",   32'(done),   32'd0);
        check("mid result", 32'(result), 32'd0);
        check("mid flags",  32'({carry, zero, ovf}), 32'd0);
        check("mid sel",    32'(au_sel), 32'd0);
        check("mid au_ab",  32'({au_a, au_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("abort nodone", 32'({busy, done}), 32'd0);
        end
        run_op("after", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
